// File: rtl/decode_execute_interlock.sv
// Decode->execute pipeline register with a load-use interlock.
// Beat layout on both streams: [31:0] raw RV32 instruction, [63:32] rs1 value,
// [95:64] rs2 value. Only the instruction word is inspected here; operand
// values ride along untouched for the forwarding unit and execute stage.
module decode_execute_interlock #(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             axis_decode_out_tvalid,
    output logic             axis_decode_out_tready,
    input  logic [95:0]      axis_decode_out_tdata,
    output logic             axis_decode_to_execute_tvalid,
    input  logic             axis_decode_to_execute_tready,
    output logic [95:0]      axis_decode_to_execute_tdata,
    output logic             stall,
    output logic [CNT_W-1:0] bubble_count
);

    localparam logic [6:0] OP_ARITHMETIC           = 7'b0110011;
    localparam logic [6:0] OP_ARITHMETIC_IMMEDIATE = 7'b0010011;
    localparam logic [6:0] OP_LOAD                 = 7'b0000011;
    localparam logic [6:0] OP_STORE                = 7'b0100011;
    localparam logic [6:0] OP_BRANCH               = 7'b1100011;
    localparam logic [6:0] OP_JALR                 = 7'b1100111;

    // With STALL_CYCLES<=1 the bubble is covered entirely by the load still
    // sitting in the output slot, so no extra countdown is needed.
    localparam int         RELOAD_I     = (STALL_CYCLES > 0) ? STALL_CYCLES - 1 : 0;
    localparam logic [1:0] LD_RELOAD    = RELOAD_I[1:0];
    localparam logic       INTERLOCK_EN = (STALL_CYCLES > 0);

    typedef enum logic {RUN = 1'b0, INTERLOCK = 1'b1} state_t;

    state_t     state;
    logic [4:0] ld_rd_q;
    logic [1:0] ld_cnt_q;

    // Incoming instruction fields
    logic [6:0] in_opcode;
    logic [4:0] in_rs1;
    logic [4:0] in_rs2;
    logic       uses_rs1;
    logic       uses_rs2;

    // Held instruction fields
    logic [6:0] out_opcode;
    logic [4:0] out_rd;
    logic       out_is_load;

    logic       adv;
    logic       in_fire;
    logic       haz_a;
    logic       haz_b;
    logic       hazard;
    logic [4:0] chk_reg [2];
    logic [1:0] dep_vec;
    logic       unused_bits;

    assign in_opcode   = axis_decode_out_tdata[6:0];
    assign in_rs1      = axis_decode_out_tdata[19:15];
    assign in_rs2      = axis_decode_out_tdata[24:20];
    assign out_opcode  = axis_decode_to_execute_tdata[6:0];
    assign out_rd      = axis_decode_to_execute_tdata[11:7];
    assign out_is_load = (out_opcode == OP_LOAD);

    // Immediates, funct fields and operand values are carried, not decoded.
    assign unused_bits = ^{axis_decode_out_tdata[95:25], axis_decode_out_tdata[14:7]};

    assign uses_rs1 = (in_opcode == OP_ARITHMETIC) || (in_opcode == OP_ARITHMETIC_IMMEDIATE) ||
                      (in_opcode == OP_LOAD)       || (in_opcode == OP_STORE) ||
                      (in_opcode == OP_BRANCH)     || (in_opcode == OP_JALR);
    assign uses_rs2 = (in_opcode == OP_ARITHMETIC) || (in_opcode == OP_STORE) ||
                      (in_opcode == OP_BRANCH);

    // Producer registers to test the incoming beat against:
    // slot 0 = load currently in the output register, slot 1 = recently issued load.
    assign chk_reg[0] = out_rd;
    assign chk_reg[1] = ld_rd_q;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dep
            assign dep_vec[gi] = axis_decode_out_tvalid && (chk_reg[gi] != 5'd0) &&
                                 ((uses_rs1 && (in_rs1 == chk_reg[gi])) ||
                                  (uses_rs2 && (in_rs2 == chk_reg[gi])));
        end
    endgenerate

    assign haz_a  = axis_decode_to_execute_tvalid && out_is_load && INTERLOCK_EN && dep_vec[0];
    assign haz_b  = (ld_cnt_q != 2'd0) && dep_vec[1];
    assign hazard = haz_a || haz_b;

    assign adv                    = !axis_decode_to_execute_tvalid || axis_decode_to_execute_tready;
    assign axis_decode_out_tready = adv && !hazard && !flush;
    assign stall                  = adv && hazard && !flush;
    assign in_fire                = axis_decode_out_tvalid && axis_decode_out_tready;

    // Output slot: load on advance, drop to a bubble when nothing is accepted, squash on flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            axis_decode_to_execute_tvalid <= 1'b0;
            axis_decode_to_execute_tdata  <= '0;
        end else if (flush) begin
            axis_decode_to_execute_tvalid <= 1'b0;
        end else if (adv) begin
            if (in_fire) begin
                axis_decode_to_execute_tvalid <= 1'b1;
                axis_decode_to_execute_tdata  <= axis_decode_out_tdata;
            end else begin
                axis_decode_to_execute_tvalid <= 1'b0;
            end
        end
    end

    // Track a load that has just left for execute; countdown covers the extra stall cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_rd_q  <= 5'd0;
            ld_cnt_q <= 2'd0;
        end else if (flush) begin
            ld_cnt_q <= 2'd0;
        end else if (adv) begin
            if (axis_decode_to_execute_tvalid && out_is_load && (out_rd != 5'd0) &&
                axis_decode_to_execute_tready) begin
                ld_rd_q  <= out_rd;
                ld_cnt_q <= LD_RELOAD;
            end else if (ld_cnt_q != 2'd0) begin
                ld_cnt_q <= ld_cnt_q - 2'd1;
            end
        end
    end

    // Saturating count of bubbles inserted by the interlock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_count <= '0;
        end else if (stall && (bubble_count != {CNT_W{1'b1}})) begin
            bubble_count <= bubble_count + CNT_W'(1);
        end
    end

    // Interlock state: entered when a bubble is inserted, left once the hazard clears or on flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else if (flush) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:       if (stall)   state <= INTERLOCK;
                INTERLOCK: if (!hazard) state <= RUN;
                default:   state <= RUN;
            endcase
        end
    end

    // While interlocked the output slot always holds a bubble
    a_interlock_bubble: assert property (@(posedge clk) disable iff (!rst_n)
        (state == INTERLOCK) |-> !axis_decode_to_execute_tvalid);

endmodule

// File: tb/tb_decode_execute_interlock.sv
`timescale 1ns/1ps
module tb_decode_execute_interlock;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    // Instance A: STALL_CYCLES=1
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_stall;
    logic [95:0] a_in_data, a_out_data;
    logic [31:0] a_bcnt;
    // Instance B: STALL_CYCLES=2
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_stall;
    logic [95:0] b_in_data, b_out_data;
    logic [31:0] b_bcnt;

    int checks = 0;
    int errors = 0;

    decode_execute_interlock #(.STALL_CYCLES(1), .CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush),
        .axis_decode_out_tvalid(a_in_valid), .axis_decode_out_tready(a_in_ready),
        .axis_decode_out_tdata(a_in_data),
        .axis_decode_to_execute_tvalid(a_out_valid), .axis_decode_to_execute_tready(a_out_ready),
        .axis_decode_to_execute_tdata(a_out_data),
        .stall(a_stall), .bubble_count(a_bcnt)
    );

    decode_execute_interlock #(.STALL_CYCLES(2), .CNT_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .axis_decode_out_tvalid(b_in_valid), .axis_decode_out_tready(b_in_ready),
        .axis_decode_out_tdata(b_in_data),
        .axis_decode_to_execute_tvalid(b_out_valid), .axis_decode_to_execute_tready(b_out_ready),
        .axis_decode_to_execute_tdata(b_out_data),
        .stall(b_stall), .bubble_count(b_bcnt)
    );

    // One line per beat delivered to execute
    always @(posedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) $display("A exec instr=%h", a_out_data[31:0]);
        if (rst_n && b_out_valid && b_out_ready) $display("B exec instr=%h", b_out_data[31:0]);
    end

    function automatic logic [95:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {32'hB0B0_0000, 32'hA0A0_0000 | 32'(rd), {12'h004, rs1, 3'b010, rd, 7'b0000011}};
    endfunction
    function automatic logic [95:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {32'h0000_2222, 32'h0000_1111, {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011}};
    endfunction
    function automatic logic [95:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1);
        return {32'h0, 32'h0000_3333, {12'h001, rs1, 3'b000, rd, 7'b0010011}};
    endfunction

    logic [95:0] lw5, lw0, add651, add652, add602, addi71;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got=%0b exp=0", a_out_valid); end
        checks++; if (a_out_data !== 96'h0) begin errors++; $display("FAIL rst_tdata got=%h exp=0", a_out_data); end
        checks++; if (a_bcnt !== 32'd0) begin errors++; $display("FAIL rst_bcnt got=%0d exp=0", a_bcnt); end
        checks++; if (dut_a.ld_cnt_q !== 2'd0) begin errors++; $display("FAIL rst_ldcnt got=%0d exp=0", dut_a.ld_cnt_q); end
        checks++; if (b_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%0b exp=0", b_stall); end
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // lw x5 ; add x6,x5,x1 with STALL=1: one bubble between them
    task automatic test_load_use();
        logic [31:0] base;
        base = a_bcnt;
        a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = lw5; #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL lu_accept_lw got=%0b exp=1", a_in_ready); end
        tick();
        a_in_data = add651; #1;
        checks++; if (a_out_data !== lw5 || a_out_valid !== 1'b1) begin errors++; $display("FAIL lu_out_lw got=%h exp=%h", a_out_data, lw5); end
        checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%0b exp=1", a_stall); end
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL lu_hold got=%0b exp=0", a_in_ready); end
        tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got=%0b exp=0", a_out_valid); end
        checks++; if (a_stall !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL lu_release stall=%0b ready=%0b exp 0/1", a_stall, a_in_ready); end
        tick();
        a_in_valid = 1'b0; #1;
        checks++; if (a_out_data !== add651 || a_out_valid !== 1'b1) begin errors++; $display("FAIL lu_out_add got=%h exp=%h", a_out_data, add651); end
        checks++; if (a_bcnt !== base + 32'd1) begin errors++; $display("FAIL lu_bcnt got=%0d exp=%0d", a_bcnt, base + 32'd1); end
    endtask

    // lw x0 ; add x6,x0,x2: x0 never interlocks
    task automatic test_x0();
        logic [31:0] base;
        base = a_bcnt;
        a_in_valid = 1'b1; a_in_data = lw0; #1;
        tick();
        a_in_data = add602; #1;
        checks++; if (a_stall !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL x0_nostall stall=%0b ready=%0b exp 0/1", a_stall, a_in_ready); end
        tick();
        a_in_valid = 1'b0; #1;
        checks++; if (a_out_data !== add602 || a_out_valid !== 1'b1) begin errors++; $display("FAIL x0_out got=%h exp=%h", a_out_data, add602); end
        checks++; if (a_bcnt !== base) begin errors++; $display("FAIL x0_bcnt got=%0d exp=%0d", a_bcnt, base); end
    endtask

    // lw x5 ; addi x7,x1,1 ; add x6,x5,x2 with STALL=1: no bubble
    task automatic test_indep_stall1();
        logic [31:0] base;
        logic [95:0] seq [3];
        base = a_bcnt;
        seq[0] = lw5; seq[1] = addi71; seq[2] = add652;
        a_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in_data = seq[i]; #1;
            checks++; if (a_stall !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL ind1_beat%0d stall=%0b ready=%0b exp 0/1", i, a_stall, a_in_ready); end
            tick();
        end
        a_in_valid = 1'b0; #1;
        checks++; if (a_out_data !== add652) begin errors++; $display("FAIL ind1_out got=%h exp=%h", a_out_data, add652); end
        checks++; if (a_bcnt !== base) begin errors++; $display("FAIL ind1_bcnt got=%0d exp=%0d", a_bcnt, base); end
    endtask

    // STALL=2: gap of one instruction still needs one bubble; back-to-back needs two
    task automatic test_stall2();
        b_out_ready = 1'b1; b_in_valid = 1'b1; b_in_data = lw5; #1;
        tick();
        b_in_data = addi71; #1;
        checks++; if (b_stall !== 1'b0) begin errors++; $display("FAIL s2_addi stall=%0b exp=0", b_stall); end
        tick();
        b_in_data = add652; #1;
        checks++; if (b_stall !== 1'b1 || b_in_ready !== 1'b0) begin errors++; $display("FAIL s2_add_held stall=%0b ready=%0b exp 1/0", b_stall, b_in_ready); end
        tick();
        checks++; if (b_stall !== 1'b0 || b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin errors++; $display("FAIL s2_add_go stall=%0b ready=%0b valid=%0b exp 0/1/0", b_stall, b_in_ready, b_out_valid); end
        tick();
        b_in_valid = 1'b0; #1;
        checks++; if (b_out_data !== add652) begin errors++; $display("FAIL s2_out got=%h exp=%h", b_out_data, add652); end
        checks++; if (b_bcnt !== 32'd1) begin errors++; $display("FAIL s2_bcnt got=%0d exp=1", b_bcnt); end
        // back-to-back dependent
        b_in_valid = 1'b1; b_in_data = lw5;
        tick();
        b_in_data = add651; #1;
        checks++; if (b_stall !== 1'b1) begin errors++; $display("FAIL s2_b2b_1 stall=%0b exp=1", b_stall); end
        tick();
        checks++; if (b_stall !== 1'b1) begin errors++; $display("FAIL s2_b2b_2 stall=%0b exp=1", b_stall); end
        tick();
        checks++; if (b_stall !== 1'b0 || b_in_ready !== 1'b1) begin errors++; $display("FAIL s2_b2b_go stall=%0b ready=%0b exp 0/1", b_stall, b_in_ready); end
        tick();
        b_in_valid = 1'b0; #1;
        checks++; if (b_bcnt !== 32'd3) begin errors++; $display("FAIL s2_b2b_bcnt got=%0d exp=3", b_bcnt); end
    endtask

    // Held load under backpressure: nothing moves, then exactly one bubble
    task automatic test_backpressure();
        logic [31:0] base;
        base = a_bcnt;
        a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = lw5;
        tick();
        a_out_ready = 1'b0; a_in_data = add651;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (a_out_data !== lw5 || a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold%0d got=%h exp=%h", i, a_out_data, lw5); end
            checks++; if (a_in_ready !== 1'b0 || a_stall !== 1'b0) begin errors++; $display("FAIL bp_wait%0d ready=%0b stall=%0b exp 0/0", i, a_in_ready, a_stall); end
            tick();
        end
        a_out_ready = 1'b1; #1;
        checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL bp_release_stall got=%0b exp=1", a_stall); end
        tick();
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_bubble valid=%0b ready=%0b exp 0/1", a_out_valid, a_in_ready); end
        tick();
        a_in_valid = 1'b0; #1;
        checks++; if (a_out_data !== add651 || a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_out got=%h exp=%h", a_out_data, add651); end
        checks++; if (a_bcnt !== base + 32'd1) begin errors++; $display("FAIL bp_bcnt got=%0d exp=%0d", a_bcnt, base + 32'd1); end
    endtask

    // Flush while interlocked (STALL=2)
    task automatic test_flush();
        logic [31:0] base;
        logic        st;
        base = b_bcnt;
        b_out_ready = 1'b1; b_in_valid = 1'b1; b_in_data = lw5;
        tick();
        b_in_data = add651;
        tick();
        st = dut_b.state;
        checks++; if (st !== 1'b1 || b_stall !== 1'b1) begin errors++; $display("FAIL fl_interlock state=%0b stall=%0b exp 1/1", st, b_stall); end
        b_flush = 1'b1; #1;
        checks++; if (b_stall !== 1'b0 || b_in_ready !== 1'b0) begin errors++; $display("FAIL fl_during stall=%0b ready=%0b exp 0/0", b_stall, b_in_ready); end
        tick();
        b_flush = 1'b0; b_in_data = addi71; #1;
        st = dut_b.state;
        checks++; if (b_out_valid !== 1'b0 || dut_b.ld_cnt_q !== 2'd0 || st !== 1'b0) begin errors++; $display("FAIL fl_after valid=%0b ldcnt=%0d state=%0b exp 0/0/0", b_out_valid, dut_b.ld_cnt_q, st); end
        checks++; if (b_stall !== 1'b0 || b_in_ready !== 1'b1) begin errors++; $display("FAIL fl_accept stall=%0b ready=%0b exp 0/1", b_stall, b_in_ready); end
        checks++; if (b_bcnt !== base + 32'd1) begin errors++; $display("FAIL fl_bcnt got=%0d exp=%0d", b_bcnt, base + 32'd1); end
        tick();
        b_in_valid = 1'b0; #1;
        checks++; if (b_out_data !== addi71 || b_out_valid !== 1'b1) begin errors++; $display("FAIL fl_out got=%h exp=%h", b_out_data, addi71); end
    endtask

    // Asynchronous reset in the middle of an interlock (STALL=2)
    task automatic test_reset_mid();
        b_in_valid = 1'b1; b_in_data = lw5;
        tick();
        b_in_data = add651;
        tick();
        #1;
        b_in_valid = 1'b0;
        rst_n = 1'b0; #1;
        checks++; if (b_out_valid !== 1'b0 || b_bcnt !== 32'd0) begin errors++; $display("FAIL rm_async valid=%0b bcnt=%0d exp 0/0", b_out_valid, b_bcnt); end
        checks++; if (dut_b.ld_cnt_q !== 2'd0) begin errors++; $display("FAIL rm_ldcnt got=%0d exp=0", dut_b.ld_cnt_q); end
        @(negedge clk);
        rst_n = 1'b1;
        b_in_valid = 1'b1; b_in_data = add652; #1;
        checks++; if (b_stall !== 1'b0 || b_in_ready !== 1'b1) begin errors++; $display("FAIL rm_noowe stall=%0b ready=%0b exp 0/1", b_stall, b_in_ready); end
        tick();
        b_in_valid = 1'b0; #1;
        checks++; if (b_out_valid !== 1'b1 || b_out_data !== add652) begin errors++; $display("FAIL rm_latency got=%h exp=%h", b_out_data, add652); end
        checks++; if (b_bcnt !== 32'd0) begin errors++; $display("FAIL rm_bcnt got=%0d exp=0", b_bcnt); end
    endtask

    initial begin
        lw5    = enc_lw(5'd5, 5'd1);
        lw0    = enc_lw(5'd0, 5'd1);
        add651 = enc_add(5'd6, 5'd5, 5'd1);
        add652 = enc_add(5'd6, 5'd5, 5'd2);
        add602 = enc_add(5'd6, 5'd0, 5'd2);
        addi71 = enc_addi(5'd7, 5'd1);
        a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        test_reset();
        test_load_use();
        test_x0();
        test_indep_stall1();
        test_stall2();
        test_backpressure();
        test_flush();
        test_reset_mid();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
